fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 168 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Pops bytes from an upstream FIFO and transmits each as a UART frame.
// A frame is a start bit, 8 data bits LSB first, an optional even-parity bit
// and a stop bit. Each bit lasts CLKS_PER_BIT clocks.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2 .. 65535)
//   DATA_W       : payload bits per frame (8)
//
// Ports
//   clk_i          in   system clock, rising edge
//   reset_i        in   asynchronous reset, active low
//   fifo_empty_i   in   upstream FIFO empty flag
//   fifo_data_i    in   upstream FIFO read data, valid the cycle after a pop
//   parity_en_i    in   adds an even-parity bit; sampled once per frame
//   fifo_rd_en_o   out  single-cycle pop strobe
//   tx_o           out  serial line, idles high
//   busy_o         out  high from the pop strobe to the end of the stop bit
//   frame_done_o   out  one-cycle pulse in the last cycle of the stop bit
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  input  logic              parity_en_i,
  output logic              fifo_rd_en_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PREV = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_idx;
  logic [DATA_W-1:0]   shift_reg;
  logic                parity_sel;
  logic                parity_bit;
  logic                tx_q;
  logic                done_q;

  // The pop strobe must appear in the same cycle that IDLE sees a non-empty
  // FIFO, so it and busy are decoded from the state register plus the empty
  // flag. IDLE lasts only one cycle once a pop happens, which makes a second
  // consecutive strobe impossible.
  assign fifo_rd_en_o = (state == IDLE) && !fifo_empty_i;
  assign busy_o       = (state != IDLE) || fifo_rd_en_o;
  assign tx_o         = tx_q;
  assign frame_done_o = done_q;

  // Single FSM register. tx_q is updated one edge ahead of each bit so the
  // serial line comes straight from a flop. The shift register is consumed
  // LSB first, so the parity bit is computed from the byte at load time.
  // done_q is set one cycle early so it is high in the final stop cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_sel <= 1'b0;
      parity_bit <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty_i) begin
            state <= FETCH;
          end
        end

        FETCH: begin
          state <= LOAD;
        end

        LOAD: begin
          shift_reg  <= fifo_data_i;
          parity_sel <= parity_en_i;
          parity_bit <= ^fifo_data_i;
          baud_cnt   <= '0;
          bit_idx    <= '0;
          tx_q       <= 1'b0;
          state      <= START;
        end

        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt  <= '0;
            tx_q      <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              if (parity_sel) begin
                tx_q  <= parity_bit;
                state <= PARITY;
              end else begin
                tx_q  <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_q      <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            tx_q     <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_cnt == BAUD_PREV) begin
            done_q <= 1'b1;
          end
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
// Directed bench for fifo_uart_tx with CLKS_PER_BIT = 4. A small queue-based
// FIFO model feeds the DUT; every cycle of each frame is compared against a
// bit pattern built from the byte being sent.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk_i        = 1'b0;
  logic       reset_i      = 1'b0;
  logic       fifo_empty_i = 1'b1;
  logic [7:0] fifo_data_i  = 8'h00;
  logic       parity_en_i  = 1'b0;
  logic       fifo_rd_en_o;
  logic       tx_o;
  logic       busy_o;
  logic       frame_done_o;

  int compared   = 0;
  int mismatched = 0;
  int rd_count   = 0;

  logic [7:0] fifo_q[$];
  logic       pop_pending;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_data_i (fifo_data_i),
    .parity_en_i (parity_en_i),
    .fifo_rd_en_o(fifo_rd_en_o),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  // Upstream FIFO model: a strobe seen mid-cycle pops the queue just after
  // the following rising edge, so data is valid from the next cycle on.
  initial begin
    forever begin
      @(negedge clk_i);
      pop_pending = fifo_rd_en_o;
      @(posedge clk_i);
      #1;
      if (pop_pending === 1'b1 && fifo_q.size() > 0) begin
        fifo_data_i = fifo_q.pop_front();
      end
      fifo_empty_i = (fifo_q.size() == 0);
    end
  end

  // Counts pop strobes, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (fifo_rd_en_o === 1'b1) rd_count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  // Called at a falling edge; returns at the falling edge of the first
  // start-bit cycle, reporting how many high cycles passed before it.
  task automatic waitStart(output int cycles);
    cycles = 0;
    while (tx_o !== 1'b0 && cycles < 200) begin
      @(negedge clk_i);
      cycles++;
    end
    checkOutput("start_seen", {31'd0, tx_o}, 32'd0);
  endtask

  // Checks tx, frame_done and busy in every cycle of one frame. flip_at
  // toggles parity_en_i at that cycle offset of the frame (-1 = never).
  task automatic runFrame(input logic [7:0] data, input logic par, input int flip_at,
                          output int gap);
    logic [10:0] exp_bits;
    int nbits;
    nbits = par ? 11 : 10;
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = data[i];
    if (par) exp_bits[9] = ^data;
    waitStart(gap);
    for (int k = 0; k < nbits * CPB; k++) begin
      if (k == flip_at) parity_en_i = ~parity_en_i;
      checkOutput($sformatf("tx_%02h_k%0d", data, k), {31'd0, tx_o}, {31'd0, exp_bits[k/CPB]});
      checkOutput($sformatf("done_%02h_k%0d", data, k), {31'd0, frame_done_o},
                  (k == nbits * CPB - 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("busy_%02h_k%0d", data, k), {31'd0, busy_o}, 32'd1);
      @(negedge clk_i);
    end
  endtask

  initial begin
    int gap;
    int r0;

    $display("[TB] start");

    // Reset state.
    reset_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_tx", {31'd0, tx_o}, 32'd1);
    checkOutput("rst_rd", {31'd0, fifo_rd_en_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_done", {31'd0, frame_done_o}, 32'd0);
    reset_i = 1'b1;
    @(negedge clk_i);

    // Empty FIFO for 100 cycles: nothing moves.
    r0 = rd_count;
    for (int i = 0; i < 100; i++) begin
      checkOutput("idle_rd", {31'd0, fifo_rd_en_o}, 32'd0);
      checkOutput("idle_tx", {31'd0, tx_o}, 32'd1);
      checkOutput("idle_busy", {31'd0, busy_o}, 32'd0);
      @(negedge clk_i);
    end
    checkOutput("idle_rdcount", rd_count - r0, 32'd0);

    // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1.
    parity_en_i = 1'b0;
    r0 = rd_count;
    applyStimulus(8'hA5);
    runFrame(8'hA5, 1'b0, -1, gap);
    checkOutput("a5_rdcount", rd_count - r0, 32'd1);
    checkOutput("a5_busy_after", {31'd0, busy_o}, 32'd0);

    // Parity on: 0x07 gives parity 1, 0xA5 gives parity 0.
    parity_en_i = 1'b1;
    applyStimulus(8'h07);
    runFrame(8'h07, 1'b1, -1, gap);
    applyStimulus(8'hA5);
    runFrame(8'hA5, 1'b1, -1, gap);
    checkOutput("par_busy_after", {31'd0, busy_o}, 32'd0);

    // Three queued bytes back to back with 3-cycle high gaps.
    parity_en_i = 1'b0;
    r0 = rd_count;
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    runFrame(8'h01, 1'b0, -1, gap);
    runFrame(8'h02, 1'b0, -1, gap);
    checkOutput("b2b_gap1", gap, 32'd3);
    runFrame(8'h03, 1'b0, -1, gap);
    checkOutput("b2b_gap2", gap, 32'd3);
    checkOutput("b2b_rdcount", rd_count - r0, 32'd3);
    checkOutput("b2b_busy_after", {31'd0, busy_o}, 32'd0);

    // Parity enable flipped during DATA of the first frame.
    parity_en_i = 1'b0;
    applyStimulus(8'h07);
    applyStimulus(8'h03);
    runFrame(8'h07, 1'b0, 12, gap);
    runFrame(8'h03, 1'b1, -1, gap);
    checkOutput("flip_gap", gap, 32'd3);
    parity_en_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Reset during data bit 4 of 0xA5 (bit 4 is 0).
    r0 = rd_count;
    applyStimulus(8'hA5);
    waitStart(gap);
    repeat (21) @(negedge clk_i);
    checkOutput("mid_tx_before", {31'd0, tx_o}, 32'd0);
    reset_i = 1'b0;
    #1;
    checkOutput("mid_tx_async", {31'd0, tx_o}, 32'd1);
    checkOutput("mid_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("mid_rd", {31'd0, fifo_rd_en_o}, 32'd0);
    checkOutput("mid_done", {31'd0, frame_done_o}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      checkOutput("post_tx", {31'd0, tx_o}, 32'd1);
      checkOutput("post_rd", {31'd0, fifo_rd_en_o}, 32'd0);
      checkOutput("post_busy", {31'd0, busy_o}, 32'd0);
    end
    checkOutput("post_rdcount", rd_count - r0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
